uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of byte entries in the transmit FIFO (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tx_wr  input  1  single-cycle write strobe from the register block's TX data write.
REQ-005 SHALL have port tx_wdata  input  8  byte to enqueue when tx_wr is high.
REQ-006 SHALL have port baud_div  input  16  bit period minus one, in clk cycles.
REQ-007 SHALL have port ovf_clr  input  1  clears tx_ovf when high.
REQ-008 SHALL have port txd  output  1  serial line, registered, idle high.
REQ-009 SHALL have port tx_busy  output  1  high while a frame is on the line.
REQ-010 SHALL have port tx_empty  output  1  FIFO holds zero entries.
REQ-011 SHALL have port tx_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 SHALL have port tx_ovf  output  1  sticky flag, write attempted while full.

Function
REQ-013 SHALL enqueue tx_wdata on a rising edge where tx_wr=1 and tx_full=0; tx_full/tx_empty SHALL derive from the registered entry count only.
REQ-014 SHALL drop a write when tx_full=1, even if a pop occurs in the same cycle, and set tx_ovf on that edge.
REQ-015 SHALL clear tx_ovf on an edge where ovf_clr=1; if ovf_clr and a dropped write coincide, tx_ovf SHALL end up 1.
REQ-016 SHALL wrap read/write pointers modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH nor go below 0.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-018 IDLE: if FIFO non-empty, SHALL pop the head byte into a shift register, latch baud_div, and enter START on the same edge.
REQ-019 SHALL drive txd low in START, data bits LSB first in DATA, then high in STOP; each state/bit SHALL last exactly latched baud_div+1 clk cycles.
REQ-020 SHALL use the baud_div value latched at the start of the frame; changes mid-frame SHALL affect only the next frame.
REQ-021 baud_div=0 SHALL give 1 clk per bit.
REQ-022 STOP SHALL return to IDLE after one bit period; a back-to-back frame SHALL start on the next edge (one extra idle-high clk between frames).
REQ-023 Latency: with FSM in IDLE and FIFO empty, txd SHALL go low on the second rising edge after the edge that samples tx_wr.
REQ-024 tx_busy SHALL be high in every state except IDLE.
REQ-025 A pop and a write in the same cycle SHALL leave the count unchanged and both SHALL take effect.

Reset
REQ-026 On reset_n low SHALL asynchronously force: txd=1, tx_busy=0, tx_empty=1, tx_full=0, tx_ovf=0, FSM=IDLE, pointers and count=0, baud counter=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately with txd high; FIFO contents SHALL be discarded.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined: SHALL insert PARITY state after DATA carrying even parity of the 8 data bits, frame = 11 bit periods.
REQ-029 Macro UART_TX_PARITY_EN undefined: PARITY state and logic SHALL be absent, DATA goes directly to STOP, frame = 10 bit periods.

Verification
REQ-030 Reset then idle 20 clk -> txd=1, tx_empty=1, tx_busy=0, tx_ovf=0.
REQ-031 baud_div=3, write 0xA5 -> txd low 4 clk, then 1,0,1,0,0,1,0,1 each 4 clk, [parity 0 if macro], stop high 4 clk; falling edge 2 edges after write.
REQ-032 baud_div=0, write 0x01,0x02,0x03,0x04 back-to-back, FIFO_DEPTH=4 -> tx_full never asserted after first pop, four frames with one idle clk between each.
REQ-033 Stall FSM mid-frame, write 5 bytes with FIFO_DEPTH=4 -> tx_full=1 after 4th accepted write, 5th dropped, tx_ovf=1 until ovf_clr pulse.
REQ-034 Change baud_div 3->7 mid-frame -> current frame keeps 4-clk bits, next frame uses 8-clk bits.
REQ-035 Assert reset_n low during DATA of 0x55 -> txd=1 same cycle, tx_empty=1, no remaining bits emitted after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit FIFO feeding a UART serialiser.
// Frames are start bit, 8 data bits (LSB first) and a stop bit, with each
// bit held for baud_div+1 clk cycles. The bit period is captured when the
// frame starts.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_wr,
    input  logic [7:0]  tx_wdata,
    input  logic [15:0] baud_div,
    input  logic        ovf_clr,
    output logic        txd,
    output logic        tx_busy,
    output logic        tx_empty,
    output logic        tx_full,
    output logic        tx_ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [7:0]       rd_data;

    // Serialiser state
    state_t           state;
    logic [15:0]      baud_q;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             bit_done;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    // Flags come straight from the registered count so they never glitch with
    // same-cycle strobes; a write while full is dropped even if a pop happens
    assign tx_empty = (count == '0);
    assign tx_full  = (count == CNT_FULL);
    assign push     = tx_wr && !tx_full;
    assign pop      = (state == IDLE) && !tx_empty;
    assign rd_data  = mem[rd_ptr];
    assign bit_done = (baud_cnt == 16'd0);

    // Storage array: no reset needed, stale bytes are unreachable once the
    // pointers are cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_wdata;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a dropped write beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovf <= 1'b0;
        end else if (tx_wr && tx_full) begin
            tx_ovf <= 1'b1;
        end else if (ovf_clr) begin
            tx_ovf <= 1'b0;
        end
    end

    // Transmit FSM. txd is registered from the current state, so the line
    // trails the state by one clk: that gives the two-edge start latency and
    // the single idle-high clk between back-to-back frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            baud_q   <= 16'd0;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift_q  <= 8'd0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                START:   txd <= 1'b0;
                DATA:    txd <= shift_q[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  txd <= parity_q;
`endif
                default: txd <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_q  <= rd_data;
                        baud_q   <= baud_div;
                        baud_cnt <= baud_div;
                        bit_idx  <= 3'd0;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^rd_data;
`endif
                        tx_busy  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= baud_q;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= baud_q;
                        shift_q  <= {1'b0, shift_q[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        baud_cnt <= baud_q;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= 16'd0;
                        tx_busy  <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    baud_cnt <= 16'd0;
                    tx_busy  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
